// File: rtl/ram_bank_pdp_gen.sv
// Pseudo-dual-port RAM bank: masked writes, write-to-read bypass, 1/2-cycle read
// latency, per-word valid bits, power-state control and sticky error flags.
module ram_bank_pdp_gen #(
    parameter int unsigned WORDS     = 80,
    parameter int unsigned BITS      = 72,
    parameter int unsigned ADDRS     = 7,
    parameter int unsigned MASK_GRAN = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned WAKE_CYC  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WE,
    input  logic [ADDRS-1:0]          WA,
    input  logic [BITS-1:0]           WD,
    input  logic [BITS/MASK_GRAN-1:0] WM,
    input  logic                      RE,
    input  logic [ADDRS-1:0]          RA,
    output logic [BITS-1:0]           RD,
    output logic                      RD_VLD,
    input  logic                      RET_EN,
    input  logic [7:0]                SLEEP_EN,
    output logic                      READY,
    output logic [1:0]                ERR,
    input  logic                      ERR_CLR
);

    localparam int unsigned NGRP  = BITS / MASK_GRAN;
    localparam int unsigned CNT_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [ADDRS:0]   WORDS_A  = (ADDRS + 1)'(WORDS);
    localparam logic [CNT_W-1:0] WAKE_END = CNT_W'(WAKE_CYC - 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_RETAIN = 2'd1;
    localparam logic [1:0] ST_SLEEP  = 2'd2;
    localparam logic [1:0] ST_WAKE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic [1:0]       err_q, err_d;
    logic [WORDS-1:0] vld_q, vld_d;
    logic [BITS-1:0]  rd_q, rd_d;
    logic             rd_vld_q, rd_vld_d;
    logic             p_vld_q, p_vld_d;
    logic [BITS-1:0]  p_dat_q, p_dat_d;
    logic [BITS-1:0]  mem_q [WORDS];

    logic            pwr_req, accept, wa_ok, ra_ok, wr_en, rd_en;
    logic [BITS-1:0] old_word, merged, rd_word;

    // Power-state next-state logic; requests override whatever state we are in
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (RET_EN) begin
            state_d = ST_RETAIN;
        end else if (|SLEEP_EN) begin
            state_d = ST_SLEEP;
        end else begin
            case (state_q)
                ST_RETAIN, ST_SLEEP: begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_END) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A power request on the same edge blocks the operation even while still ACTIVE
    always_comb begin
        pwr_req  = RET_EN | (|SLEEP_EN);
        accept   = ready_q & ~pwr_req & ~RST;
        wa_ok    = {1'b0, WA} < WORDS_A;
        ra_ok    = {1'b0, RA} < WORDS_A;
        wr_en    = accept & WE & wa_ok;
        rd_en    = accept & RE;
        old_word = (wa_ok && vld_q[WA]) ? mem_q[WA] : '0;
        merged   = old_word;
        for (int unsigned g = 0; g < NGRP; g++) begin
            if (WM[g]) begin
                merged[g*MASK_GRAN +: MASK_GRAN] = WD[g*MASK_GRAN +: MASK_GRAN];
            end
        end
        rd_word = '0;
        if (ra_ok) begin
            if ((BYPASS != 0) && wr_en && (WA == RA)) begin
                rd_word = merged;
            end else if (vld_q[RA]) begin
                rd_word = mem_q[RA];
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (state_d == ST_SLEEP) begin
            vld_d = '0;
        end else if (wr_en) begin
            vld_d[WA] = 1'b1;
        end

        err_d = ERR_CLR ? 2'b00 : err_q;
        if (!accept && (WE || RE)) begin
            err_d[1] = 1'b1;
        end
        if (accept && ((WE && !wa_ok) || (RE && !ra_ok))) begin
            err_d[0] = 1'b1;
        end

        // Read pipeline keeps draining regardless of power state
        p_vld_d = rd_en;
        p_dat_d = rd_word;
        if (RD_LAT == 2) begin
            rd_vld_d = p_vld_q;
            rd_d     = p_vld_q ? p_dat_q : rd_q;
        end else begin
            rd_vld_d = rd_en;
            rd_d     = rd_en ? rd_word : rd_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_WAKE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= '0;
            vld_q    <= '0;
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
            p_vld_q  <= 1'b0;
            p_dat_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= (state_d == ST_ACTIVE);
            err_q    <= err_d;
            vld_q    <= vld_d;
            rd_q     <= rd_d;
            rd_vld_q <= rd_vld_d;
            p_vld_q  <= p_vld_d;
            p_dat_q  <= p_dat_d;
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[WA] <= merged;
        end
    end

    assign RD     = rd_q;
    assign RD_VLD = rd_vld_q;
    assign READY  = ready_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_ram_bank_pdp_gen.sv
// Randomized + directed bench for ram_bank_pdp_gen: two instances (latency 1 with
// bypass, latency 2 without) share stimulus and are checked against a word-level model.
module tb_ram_bank_pdp_gen;

    localparam int WORDS = 80;
    localparam int WAKE  = 4;

    logic        clk = 1'b0;
    logic        rst, we, re, ret_en, err_clr;
    logic [6:0]  wa, ra;
    logic [71:0] wd;
    logic [8:0]  wm;
    logic [7:0]  sleep_en;

    logic [71:0] rd_a, rd_b;
    logic        rdv_a, rdv_b, rdy_a, rdy_b;
    logic [1:0]  err_a, err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_bank_pdp_gen #(.RD_LAT(1), .BYPASS(1), .WAKE_CYC(WAKE)) u_dut_a (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd), .WM(wm), .RE(re), .RA(ra),
        .RD(rd_a), .RD_VLD(rdv_a), .RET_EN(ret_en), .SLEEP_EN(sleep_en),
        .READY(rdy_a), .ERR(err_a), .ERR_CLR(err_clr));

    ram_bank_pdp_gen #(.RD_LAT(2), .BYPASS(0), .WAKE_CYC(WAKE)) u_dut_b (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd), .WM(wm), .RE(re), .RA(ra),
        .RD(rd_b), .RD_VLD(rdv_b), .RET_EN(ret_en), .SLEEP_EN(sleep_en),
        .READY(rdy_b), .ERR(err_b), .ERR_CLR(err_clr));

    // Reference model state
    logic [71:0] m_mem [WORDS];
    bit          m_val [WORDS];
    bit          m_ready, m_low;
    int          m_wait;
    logic [1:0]  m_err;
    logic [71:0] m_rd_a, m_rd_b, m_pipe_d;
    bit          m_rdv_a, m_rdv_b, m_pipe_v;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          req, acc, wa_ok, ra_ok, wr;
        logic [71:0] old_w, new_w, cur, r_byp, r_old;
        if (rst) begin
            foreach (m_val[i]) m_val[i] = 0;
            m_ready = 0; m_low = 0; m_wait = 0; m_err = 2'b00;
            m_rd_a = '0; m_rd_b = '0; m_rdv_a = 0; m_rdv_b = 0;
            m_pipe_v = 0; m_pipe_d = '0;
            return;
        end
        req   = ret_en || (sleep_en != 8'h00);
        acc   = m_ready && !req;
        wa_ok = int'(wa) < WORDS;
        ra_ok = int'(ra) < WORDS;
        wr    = acc && we && wa_ok;

        if (err_clr) m_err = 2'b00;
        if (!acc && (we || re)) m_err[1] = 1'b1;
        if (acc && ((we && !wa_ok) || (re && !ra_ok))) m_err[0] = 1'b1;

        new_w = '0;
        if (wr) begin
            old_w = m_val[wa] ? m_mem[wa] : 72'h0;
            for (int g = 0; g < 9; g++)
                new_w[g*8 +: 8] = wm[g] ? wd[g*8 +: 8] : old_w[g*8 +: 8];
        end
        cur   = (ra_ok && m_val[ra]) ? m_mem[ra] : 72'h0;
        r_old = cur;
        r_byp = (wr && wa == ra) ? new_w : cur;

        m_rdv_b = m_pipe_v;
        if (m_pipe_v) m_rd_b = m_pipe_d;
        m_pipe_v = acc && re;
        m_pipe_d = r_old;
        m_rdv_a  = acc && re;
        if (m_rdv_a) m_rd_a = r_byp;

        if (wr) begin
            m_mem[wa] = new_w;
            m_val[wa] = 1;
        end

        if (req) begin
            m_ready = 0; m_low = 1; m_wait = 0;
            if (!ret_en) foreach (m_val[i]) m_val[i] = 0;
        end else if (m_low) begin
            m_low = 0; m_wait = 0;
        end else if (!m_ready) begin
            if (m_wait == WAKE - 1) m_ready = 1;
            else m_wait++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ready_a", 72'(rdy_a), 72'(m_ready));
        check_eq("ready_b", 72'(rdy_b), 72'(m_ready));
        check_eq("err_a",   72'(err_a), 72'(m_err));
        check_eq("err_b",   72'(err_b), 72'(m_err));
        check_eq("rdvld_a", 72'(rdv_a), 72'(m_rdv_a));
        check_eq("rdvld_b", 72'(rdv_b), 72'(m_rdv_b));
        check_eq("rd_a",    rd_a, m_rd_a);
        check_eq("rd_b",    rd_b, m_rd_b);
    endtask

    task automatic set_idle();
        rst = 0; we = 0; re = 0; ret_en = 0; err_clr = 0; sleep_en = 8'h00;
        wa = '0; ra = '0; wd = '0; wm = '1;
    endtask

    task automatic op(input bit w, input int a_w, input logic [71:0] d, input logic [8:0] m,
                      input bit r, input int a_r);
        we = w; wa = 7'(a_w); wd = d; wm = m; re = r; ra = 7'(a_r);
        tick();
        we = 0; re = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!rdy_a && n < 30) begin
            tick();
            n++;
        end
        check_eq("wait_ready", 72'(rdy_a), 72'(1));
    endtask

    initial begin
        int pw_left;
        set_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Wake from reset: READY low for WAKE edges then high
        for (int i = 0; i < WAKE - 1; i++) tick();
        check_eq("ready_wake_low", 72'(rdy_a), 72'(0));
        tick();
        check_eq("ready_wake_high", 72'(rdy_a), 72'(1));

        op(0, 0, '0, '1, 1, 5);
        check_eq("rd_unwritten", rd_a, 72'h0);

        // Masked write merge
        op(1, 3, {9{8'hFF}}, 9'h1FF, 0, 0);
        op(1, 3, 72'h0, 9'h001, 0, 0);
        op(0, 0, '0, '1, 1, 3);
        check_eq("masked_lat1", rd_a, {{8{8'hFF}}, 8'h00});
        check_eq("masked_lat2_pending", 72'(rdv_b), 72'(0));
        tick();
        check_eq("masked_lat2", rd_b, {{8{8'hFF}}, 8'h00});

        // Same-edge write/read: bypass vs pre-write data
        op(1, 10, {9{8'h3C}}, 9'h1FF, 0, 0);
        op(1, 10, {9{8'hA5}}, 9'h1FF, 1, 10);
        check_eq("bypass_new", rd_a, {9{8'hA5}});
        tick();
        check_eq("nobypass_old", rd_b, {9{8'h3C}});

        // Illegal addresses
        op(1, 80, {9{8'h11}}, 9'h1FF, 1, 127);
        check_eq("illegal_err", 72'(err_a), 72'(2'b01));
        check_eq("illegal_rd_zero", rd_a, 72'h0);
        err_clr = 1;
        op(0, 0, '0, '1, 1, 100);
        err_clr = 0;
        check_eq("clr_vs_new_err", 72'(err_a), 72'(2'b01));
        err_clr = 1;
        tick();
        err_clr = 0;
        check_eq("err_cleared", 72'(err_a), 72'(2'b00));

        // Retention keeps data, sleep loses it; write during WAKE is dropped
        op(1, 7, {9{8'h5A}}, 9'h1FF, 0, 0);
        ret_en = 1;
        for (int i = 0; i < 10; i++) tick();
        ret_en = 0;
        tick();
        op(1, 7, {9{8'hEE}}, 9'h1FF, 0, 0);
        check_eq("wake_drop_err", 72'(err_a), 72'(2'b10));
        wait_ready();
        op(0, 0, '0, '1, 1, 7);
        check_eq("retain_data", rd_a, {9{8'h5A}});
        tick();
        sleep_en = 8'h01;
        for (int i = 0; i < 10; i++) tick();
        sleep_en = 8'h00;
        wait_ready();
        op(0, 0, '0, '1, 1, 7);
        check_eq("sleep_lost", rd_a, 72'h0);

        // Reset with a read in flight on the latency-2 instance
        op(0, 0, '0, '1, 1, 3);
        rst = 1;
        tick();
        check_eq("rst_inflight", 72'(rdv_b), 72'(0));
        rst = 0;
        wait_ready();

        // Randomized phase
        pw_left = 0;
        for (int c = 0; c < 4000; c++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 15));
            ra = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = wa;
            wd = 72'({$urandom(), $urandom(), $urandom()});
            wm = 9'($urandom());
            err_clr = ($urandom_range(0, 19) == 0);
            if (pw_left > 0) begin
                pw_left--;
            end else begin
                ret_en = 0;
                sleep_en = 8'h00;
                if ($urandom_range(0, 59) == 0) begin
                    pw_left = $urandom_range(1, 12);
                    case ($urandom_range(0, 2))
                        0: ret_en = 1;
                        1: sleep_en = 8'(1 << $urandom_range(0, 7));
                        default: begin
                            ret_en = 1;
                            sleep_en = 8'(1 << $urandom_range(0, 7));
                        end
                    endcase
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        set_idle();
        for (int i = 0; i < 4; i++) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_bank_pdp_gen.md
# ram_bank_pdp_gen

Parametrised pseudo-dual-port RAM bank: one write port and one read port on a single clock, with per-group write masking, same-address write-to-read bypass, configurable read latency, per-word valid tracking and a power-state controller (active / retention / sleep / wake-up). It is the next-generation replacement for the fixed-geometry RAMPDP bank models and sits under the NVDLA buffer wrappers wherever a generic depth×width two-port array is required. Out-of-range addresses and operations issued while not ready are reported through sticky error flags instead of being silently ignored.

## Interface
- WORDS, 80, number of words; legal addresses are 0..WORDS-1
- BITS, 72, word width
- ADDRS, 7, address width; must satisfy 2^ADDRS ≥ WORDS
- MASK_GRAN, 8, bits per write-mask bit; BITS % MASK_GRAN == 0
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- BYPASS, 1, 1 = a same-cycle same-address read returns the newly written (merged) data
- WAKE_CYC, 4, cycles spent in WAKE before READY asserts; ≥ 1
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-high
- WE  in  1  write enable
- WA  in  ADDRS  write address
- WD  in  BITS  write data
- WM  in  BITS/MASK_GRAN  write mask; 1 = write that group
- RE  in  1  read enable
- RA  in  ADDRS  read address
- RD  out  BITS  read data; holds its value between reads
- RD_VLD  out  1  one-cycle pulse marking new RD data
- RET_EN  in  1  retention request; contents are preserved
- SLEEP_EN  in  8  any nonzero bit = sleep request; contents are lost
- READY  out  1  bank accepts operations
- ERR  out  2  sticky error flags: [0] illegal address, [1] operation dropped
- ERR_CLR  in  1  clears ERR

## Operation
- Power FSM states: ACTIVE, RETAIN, SLEEP, WAKE.
  - Reset enters WAKE with the wake counter at 0.
  - In any state, RET_EN=1 → RETAIN. RET_EN has priority over SLEEP_EN.
  - Otherwise, SLEEP_EN≠0 → SLEEP.
  - RETAIN or SLEEP with the request deasserted → WAKE, counter cleared.
  - WAKE → ACTIVE once the counter reaches WAKE_CYC-1.
- READY = (state == ACTIVE).
- Entering SLEEP clears every valid bit on the transition edge. RETAIN leaves valid bits and data untouched.
- Reset clears all valid bits, ERR, RD, RD_VLD and the read pipeline. It does not initialise the array data.
- Write: on an edge with WE=1, READY=1 and WA<WORDS:
  - mask groups with WM=1 take WD; the other groups keep their old data;
  - the word's valid bit is set, and masked-off groups of a previously invalid word read as 0.
- Read: on an edge with RE=1 and READY=1, RA is sampled.
  - Data = array word if valid, else all zeros.
  - RA ≥ WORDS returns all zeros.
  - Data appears on RD with RD_VLD=1 after RD_LAT edges.
- Same-edge write and read to the same legal address:
  - BYPASS=1 returns the post-write merged word.
  - BYPASS=0 returns the pre-write word.
- Illegal address: WE or RE with an address ≥ WORDS while READY sets ERR[0]. The write is dropped; the read still produces RD_VLD with zero data.
- Dropped operation: WE or RE while READY=0 sets ERR[1]. No array change and no RD_VLD.
- ERR_CLR=1 clears both flags. A new error on the same edge wins (flag stays 1).
- Reads already in the pipeline when READY drops still complete and pulse RD_VLD.

## Timing
- Reset values: RD=0, RD_VLD=0, READY=0, ERR=0. READY rises WAKE_CYC edges after the first edge with RST=0.
- Read issued at edge N: RD/RD_VLD update at edge N+RD_LAT. Back-to-back reads sustain one result per cycle.
- Write at edge N is visible to a read sampled at edge N+1, or at edge N itself when BYPASS=1.
- RET_EN or SLEEP_EN asserted at edge N: READY=0 after edge N. An operation presented at edge N is dropped and sets ERR[1].
- RST asserted mid-pipeline: no RD_VLD is produced for reads in flight.

## Test plan
- Reset then idle (WAKE_CYC=4): READY=0 for 4 cycles, then 1. Read of address 5 → RD=0 and RD_VLD after RD_LAT cycles.
- Masked write: write addr 3 = 0xFF..FF with WM all ones, then write 0x00..00 with WM=0x01, then read → low byte 0x00, rest 0xFF. Repeat with RD_LAT=2 and check the 2-cycle latency.
- Same-cycle write and read to addr 10 with WD=0xA5 replicated: BYPASS=1 → RD=0xA5 pattern; BYPASS=0 → previous contents.
- Write addr 80 and read addr 127 (WORDS=80): ERR=2'b01, no array change, RD=0 with RD_VLD. ERR_CLR together with another illegal read → ERR[0] stays 1.
- Write addr 7, assert RET_EN for 10 cycles, release, wait for READY, read → data preserved. Repeat with SLEEP_EN=0x01 → read returns 0.
- Issue WE while in WAKE → ERR[1]=1 and no write. Assert RST while a read is in flight → RD_VLD stays 0.
